// File: rtl/gray_sched.sv
// Run scheduler for a shared 3-bit Gray counter: arbitrates two requesters, clears and steps the counter N times, returns result.
// Build option: define GRAY_SCHED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module gray_sched #(
  parameter int unsigned LW = 8,
  parameter int unsigned WW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req_i,
  input  logic [LW-1:0] len0_i,
  input  logic [LW-1:0] len1_i,
  input  logic [2:0]    cnt_val_i,
  input  logic          cnt_ovf_i,
  output logic [1:0]    grant_o,
  output logic [1:0]    done_o,
  output logic [2:0]    result_o,
  output logic [WW-1:0] wraps_o,
  output logic          ovf_seen_o,
  output logic          cnt_en_o,
  output logic          cnt_rst_o
);

  localparam logic [2:0]    GRAY_TOP = 3'b100;
  localparam logic [WW-1:0] WRAP_MAX = {WW{1'b1}};

  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          win_q, win_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    done_q, done_d;
  logic [2:0]    result_q, result_d;
  logic [WW-1:0] wraps_q, wraps_d;
  logic          ovf_q, ovf_d;
  logic [WW-1:0] acc_wraps_q, acc_wraps_d;
  logic          acc_ovf_q, acc_ovf_d;
  logic          cnt_en_q, cnt_en_d;
  logic          cnt_rst_q, cnt_rst_d;
  logic          pick_c;
`ifndef GRAY_SCHED_PRIO_EN
  logic          last_q, last_d;
`endif

  // Winner index among active requesters (only meaningful when req_i != 0)
  always_comb begin
`ifdef GRAY_SCHED_PRIO_EN
    pick_c = ~req_i[0];
`else
    if (req_i == 2'b11) pick_c = ~last_q;
    else                pick_c = req_i[1];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      win_q       <= 1'b0;
      grant_q     <= '0;
      done_q      <= '0;
      result_q    <= '0;
      wraps_q     <= '0;
      ovf_q       <= 1'b0;
      acc_wraps_q <= '0;
      acc_ovf_q   <= 1'b0;
      cnt_en_q    <= 1'b0;
      cnt_rst_q   <= 1'b0;
`ifndef GRAY_SCHED_PRIO_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      win_q       <= win_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      result_q    <= result_d;
      wraps_q     <= wraps_d;
      ovf_q       <= ovf_d;
      acc_wraps_q <= acc_wraps_d;
      acc_ovf_q   <= acc_ovf_d;
      cnt_en_q    <= cnt_en_d;
      cnt_rst_q   <= cnt_rst_d;
`ifndef GRAY_SCHED_PRIO_EN
      last_q      <= last_d;
`endif
    end
  end

  // Next state; counter controls are computed for the state being entered so they line up with it
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    win_d       = win_q;
    grant_d     = grant_q;
    done_d      = '0;
    result_d    = result_q;
    wraps_d     = wraps_q;
    ovf_d       = ovf_q;
    acc_wraps_d = acc_wraps_q;
    acc_ovf_d   = acc_ovf_q;
    cnt_en_d    = 1'b0;
    cnt_rst_d   = 1'b0;
`ifndef GRAY_SCHED_PRIO_EN
    last_d      = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_i != 2'b00) begin
          win_d     = pick_c;
          rem_d     = pick_c ? len1_i : len0_i;
          grant_d   = pick_c ? 2'b10 : 2'b01;
          cnt_rst_d = 1'b1;
          state_d   = CLR;
`ifndef GRAY_SCHED_PRIO_EN
          last_d    = pick_c;
`endif
        end
      end
      CLR: begin
        acc_wraps_d = '0;
        acc_ovf_d   = 1'b0;
        if (rem_q == '0) begin
          state_d = DONE;
        end else begin
          state_d  = RUN;
          cnt_en_d = 1'b1;
        end
      end
      RUN: begin
        rem_d = rem_q - LW'(1);
        if ((cnt_val_i == GRAY_TOP) && (acc_wraps_q != WRAP_MAX))
          acc_wraps_d = acc_wraps_q + WW'(1);
        if (cnt_ovf_i)
          acc_ovf_d = 1'b1;
        if (rem_q == LW'(1)) state_d = DONE;
        else                 cnt_en_d = 1'b1;
      end
      DONE: begin
        result_d = cnt_val_i;
        wraps_d  = acc_wraps_q;
        ovf_d    = acc_ovf_q;
        done_d   = win_q ? 2'b10 : 2'b01;
        grant_d  = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_o    = grant_q;
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign wraps_o    = wraps_q;
  assign ovf_seen_o = ovf_q;
  assign cnt_en_o   = cnt_en_q;
  assign cnt_rst_o  = cnt_rst_q;

endmodule
